controlador_jogo: RTL and testbench

Round controller for the two-player sequence-memory game. It generates a 4-bit target sequence for each player and shows both for a fixed window. It then collects each player's confirmed entry and compares both entries against their targets; the round passes only if both match. It tracks the level and ends the game on a miss, a timeout or a final win. It sits between the button/switch debouncers and the LED/7-segment display drivers.

---
 rtl/jogo_pkg.sv | 19 +
 rtl/gerador_lfsr.sv | 18 +
 rtl/controlador_jogo.sv | 154 +++++++++++++++
 tb/tb_controlador_jogo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - shared state encoding and LFSR constants for the memory game
package jogo_pkg;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    GERA      = 3'd1,
    EXIBE     = 3'd2,
    ESPERA    = 3'd3,
    VERIFICA  = 3'd4,
    RESULTADO = 3'd5,
    FIM       = 3'd6
  } estado_t;

  localparam logic [7:0] SEMENTE_LFSR = 8'hA5;
  // Taps x^8+x^6+x^5+x^4 -> bits 7,5,4,3
  localparam logic [7:0] MASCARA_LFSR = 8'hB8;
  localparam int         LARGURA_SEQ  = 4;

endpackage

// File: rtl/gerador_lfsr.sv
// rtl/gerador_lfsr.sv - free-running 8-bit Fibonacci LFSR, reseeded on reset
module gerador_lfsr
  import jogo_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] valor
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valor <= SEMENTE_LFSR;
    end else begin
      valor <= {valor[6:0], ^(valor & MASCARA_LFSR)};
    end
  end

endmodule

// File: rtl/controlador_jogo.sv
// rtl/controlador_jogo.sv - two-player round controller; CONTROLADOR_TIMEOUT_EN enables the entry timeout
module controlador_jogo
  import jogo_pkg::*;
#(
  parameter int TEMPO_EXIBICAO = 8,
  parameter int TEMPO_LIMITE   = 64,
  parameter int NIVEL_MAX      = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   iniciar,
  input  logic [LARGURA_SEQ-1:0] entrada_0,
  input  logic                   confirma_0,
  input  logic [LARGURA_SEQ-1:0] entrada_1,
  input  logic                   confirma_1,
  output logic                   exibe,
  output logic [LARGURA_SEQ-1:0] sequencia_0,
  output logic [LARGURA_SEQ-1:0] sequencia_1,
  output logic                   acerto,
  output logic                   erro,
  output logic [3:0]             nivel,
  output logic                   fim_jogo,
  output logic                   vitoria
);

  estado_t                estado, estado_prox;
  logic [7:0]             lfsr;
  logic [LARGURA_SEQ-1:0] alvo_0, alvo_1, ent_0, ent_1;
  logic                   feito_0, feito_1;
  logic [15:0]            contador;
  logic                   passou;
  logic                   expirou;

  gerador_lfsr u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .valor  (lfsr)
  );

`ifdef CONTROLADOR_TIMEOUT_EN
  assign expirou = (contador == 16'(TEMPO_LIMITE - 1));
`else
  logic [31:0] unused_tempo_limite;
  assign unused_tempo_limite = 32'(TEMPO_LIMITE);
  assign expirou = 1'b0;
`endif

  always_comb begin
    estado_prox = estado;
    passou      = 1'b0;
    case (estado)
      OCIOSO:    if (iniciar) estado_prox = GERA;
      GERA:      estado_prox = EXIBE;
      EXIBE:     if (contador == 16'(TEMPO_EXIBICAO - 1)) estado_prox = ESPERA;
      ESPERA: begin
        // A confirm completing both entries in the last cycle beats the timeout
        if ((feito_0 || confirma_0) && (feito_1 || confirma_1)) begin
          estado_prox = VERIFICA;
        end else if (expirou) begin
          estado_prox = RESULTADO;
        end
      end
      VERIFICA: begin
        passou      = (ent_0 == alvo_0) && (ent_1 == alvo_1);
        estado_prox = RESULTADO;
      end
      RESULTADO: begin
        if (acerto && (nivel != 4'(NIVEL_MAX))) estado_prox = GERA;
        else estado_prox = FIM;
      end
      FIM:       if (iniciar) estado_prox = GERA;
      default:   estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado      <= OCIOSO;
      exibe       <= 1'b0;
      sequencia_0 <= '0;
      sequencia_1 <= '0;
      acerto      <= 1'b0;
      erro        <= 1'b0;
      nivel       <= '0;
      fim_jogo    <= 1'b0;
      vitoria     <= 1'b0;
      alvo_0      <= '0;
      alvo_1      <= '0;
      ent_0       <= '0;
      ent_1       <= '0;
      feito_0     <= 1'b0;
      feito_1     <= 1'b0;
      contador    <= '0;
    end else begin
      estado   <= estado_prox;
      exibe    <= (estado_prox == EXIBE);
      fim_jogo <= (estado_prox == FIM);
      acerto   <= (estado_prox == RESULTADO) && passou;
      erro     <= (estado_prox == RESULTADO) && !passou;
      // Targets are loaded on the same edge that enters EXIBE, so take them from the LFSR there
      if (estado_prox == EXIBE) begin
        sequencia_0 <= (estado == GERA) ? lfsr[3:0] : alvo_0;
        sequencia_1 <= (estado == GERA) ? lfsr[7:4] : alvo_1;
      end else begin
        sequencia_0 <= '0;
        sequencia_1 <= '0;
      end

      case (estado)
        OCIOSO, FIM: begin
          if (iniciar) begin
            nivel   <= '0;
            vitoria <= 1'b0;
          end
        end
        GERA: begin
          alvo_0   <= lfsr[3:0];
          alvo_1   <= lfsr[7:4];
          ent_0    <= '0;
          ent_1    <= '0;
          feito_0  <= 1'b0;
          feito_1  <= 1'b0;
          contador <= '0;
        end
        EXIBE: begin
          contador <= (estado_prox == ESPERA) ? 16'd0 : contador + 16'd1;
        end
        ESPERA: begin
          if (confirma_0 && !feito_0) begin
            ent_0   <= entrada_0;
            feito_0 <= 1'b1;
          end
          if (confirma_1 && !feito_1) begin
            ent_1   <= entrada_1;
            feito_1 <= 1'b1;
          end
`ifdef CONTROLADOR_TIMEOUT_EN
          contador <= contador + 16'd1;
`endif
        end
        RESULTADO: begin
          if (acerto) begin
            if (nivel == 4'(NIVEL_MAX)) vitoria <= 1'b1;
            else nivel <= nivel + 4'd1;
          end else begin
            vitoria <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_jogo.sv
// tb/tb_controlador_jogo.sv - scoreboard bench for controlador_jogo
module tb_controlador_jogo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] entrada_0 = '0, entrada_1 = '0;
  logic       confirma_0 = 1'b0, confirma_1 = 1'b0;
  logic       exibe, acerto, erro, fim_jogo, vitoria;
  logic [3:0] sequencia_0, sequencia_1, nivel;

  controlador_jogo #(.TEMPO_EXIBICAO(8), .TEMPO_LIMITE(4), .NIVEL_MAX(2)) dut (
    .clk(clk), .reset_n(reset_n), .iniciar(iniciar),
    .entrada_0(entrada_0), .confirma_0(confirma_0),
    .entrada_1(entrada_1), .confirma_1(confirma_1),
    .exibe(exibe), .sequencia_0(sequencia_0), .sequencia_1(sequencia_1),
    .acerto(acerto), .erro(erro), .nivel(nivel),
    .fim_jogo(fim_jogo), .vitoria(vitoria)
  );

  always #5 clk = ~clk;

  int n_verif = 0;
  int n_falha = 0;
  int ciclo = 0;
  logic [7:0] m_lfsr;

  always @(posedge clk) begin
    ciclo <= ciclo + 1;
    if (!reset_n) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  typedef struct {
    logic       acerto;
    logic       erro;
    logic [3:0] nivel;
    int         ciclo;
  } esperado_t;
  esperado_t fila[$];
  esperado_t e;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_verif++;
    if (atual !== esperado) begin
      n_falha++;
      $display("FAIL %s: atual=%0h esperado=%0h", nome, atual, esperado);
    end
  endtask

  logic [3:0] alvo_0, alvo_1;
  logic [7:0] lfsr_ant;
  bit         exibe_ant = 1'b0;
  bit         descarta = 1'b0;
  int         corrida = 0;

  // Monitor: result pulses against the queue, display window and targets against the model
  always @(negedge clk) begin
    if (acerto === 1'b1 || erro === 1'b1) begin
      if (fila.size() == 0) begin
        chk("pulso_inesperado", {30'd0, acerto, erro}, 32'd0);
      end else begin
        e = fila.pop_front();
        chk("acerto", acerto, e.acerto);
        chk("erro", erro, e.erro);
        chk("nivel_resultado", nivel, e.nivel);
        chk("latencia", ciclo, e.ciclo);
      end
    end
    if (exibe === 1'b1 && !exibe_ant) begin
      alvo_0 = lfsr_ant[3:0];
      alvo_1 = lfsr_ant[7:4];
      chk("sequencia_0", sequencia_0, alvo_0);
      chk("sequencia_1", sequencia_1, alvo_1);
      corrida = 1;
    end else if (exibe === 1'b1) begin
      corrida++;
    end
    if (exibe !== 1'b1 && exibe_ant) begin
      if (descarta) descarta = 1'b0;
      else chk("duracao_exibe", corrida, 8);
    end
    exibe_ant = (exibe === 1'b1);
    lfsr_ant  = m_lfsr;
  end

  task automatic passo();
    @(negedge clk);
    #1;
  endtask

  task automatic espera_exibe(input logic val);
    for (int i = 0; i < 200 && exibe !== val; i++) passo();
    chk("espera_exibe", exibe, val);
  endtask

  task automatic inicia();
    iniciar = 1'b1;
    passo();
    iniciar = 1'b0;
    chk("exibe_em_gera", exibe, 0);
    passo();
    chk("exibe_sobe", exibe, 1);
  endtask

  task automatic conf(input bit c0, input bit c1, input logic [3:0] v0, input logic [3:0] v1);
    confirma_0 = c0;
    confirma_1 = c1;
    entrada_0  = v0;
    entrada_1  = v1;
    passo();
    confirma_0 = 1'b0;
    confirma_1 = 1'b0;
  endtask

  task automatic saidas_zero(input string nome);
    chk(nome, {exibe, sequencia_0, sequencia_1, acerto, erro, nivel, fim_jogo, vitoria}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: atual=timeout esperado=fim");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) passo();
    saidas_zero("reset_inicial");
    reset_n = 1'b1;
    repeat (3) passo();

    // Round at level 0: matching entries, confirms on separate cycles
    inicia();
    espera_exibe(0);
    conf(1, 0, alvo_0, 4'h0);
    fila.push_back('{1'b1, 1'b0, 4'd0, ciclo + 2});
    conf(0, 1, 4'h0, alvo_1);
    passo();
    passo();
    chk("nivel_1", nivel, 1);
    chk("fim_apos_acerto", fim_jogo, 0);

    // Level 1: confirms during EXIBE and repeated player 0 confirms are ignored
    espera_exibe(1);
    conf(1, 1, alvo_0 ^ 4'h5, alvo_1 ^ 4'h3);
    espera_exibe(0);
    conf(1, 0, alvo_0, 4'h0);
    conf(1, 0, alvo_0 ^ 4'h8, 4'h0);
    fila.push_back('{1'b1, 1'b0, 4'd1, ciclo + 2});
    conf(0, 1, 4'h0, alvo_1);
    passo();
    passo();
    chk("nivel_2", nivel, 2);

    // Level 2 = NIVEL_MAX: simultaneous confirms, win
    espera_exibe(1);
    espera_exibe(0);
    fila.push_back('{1'b1, 1'b0, 4'd2, ciclo + 2});
    conf(1, 1, alvo_0, alvo_1);
    passo();
    passo();
    chk("fim_vitoria", fim_jogo, 1);
    chk("vitoria", vitoria, 1);
    chk("nivel_final", nivel, 2);

    // Restart from FIM, player 1 misses by one bit
    inicia();
    chk("nivel_reinicio", nivel, 0);
    chk("fim_limpo", {fim_jogo, vitoria}, 0);
    espera_exibe(0);
    fila.push_back('{1'b0, 1'b1, 4'd0, ciclo + 2});
    conf(1, 1, alvo_0, alvo_1 ^ 4'b0001);
    passo();
    passo();
    chk("fim_erro", fim_jogo, 1);
    chk("vitoria_erro", vitoria, 0);
    chk("nivel_erro", nivel, 0);

    // Only player 0 confirms
    inicia();
    espera_exibe(0);
`ifdef CONTROLADOR_TIMEOUT_EN
    fila.push_back('{1'b0, 1'b1, 4'd0, ciclo + 4});
    conf(1, 0, alvo_0, 4'h0);
    repeat (6) passo();
    chk("fim_timeout", fim_jogo, 1);
`else
    conf(1, 0, alvo_0, 4'h0);
    repeat (1000) passo();
    chk("sem_timeout", {fim_jogo, erro, exibe}, 0);
    reset_n = 1'b0;
    passo();
    reset_n = 1'b1;
    saidas_zero("reset_espera");
`endif

    // Reset for one edge in the middle of EXIBE
    inicia();
    repeat (3) passo();
    descarta = 1'b1;
    reset_n  = 1'b0;
    passo();
    saidas_zero("reset_exibe");
    reset_n = 1'b1;
    repeat (20) passo();
    chk("sem_retomar", exibe, 0);
    inicia();
    espera_exibe(0);

    passo();
    chk("fila_vazia", fila.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falha);
    $finish;
  end

endmodule
